// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: runs a sequential fetch PC ahead of execution,
// issues word reads on the arbiter handshake, and buffers the returned
// {pc, instr, exception} tuples in a DEPTH-entry FIFO for InstructionFetch.
// Optional feature macro: PREFETCH_BYPASS_EN (drives the response straight to
// the head outputs when the FIFO is empty).
module fetch_prefetch_queue #(
  parameter int unsigned               DEPTH         = 4,
  parameter logic [31:0]               RESET_PC      = 32'h0000_0000,
  parameter int unsigned               EXCEPTION_LEN = 4,
  parameter logic [EXCEPTION_LEN-1:0]  EXCEP_OK      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              pcWrite_In,
  input  logic                     pcFlush_In,
  input  logic                     pop_In,
  input  logic                     execLockRead_In,
  output logic                     valid_Out,
  output logic [31:0]              instr_Out,
  output logic [31:0]              pc_Out,
  output logic [EXCEPTION_LEN-1:0] exception_Out,
  output logic [31:0]              memAddr_Out,
  output logic [31:0]              memData_Out,
  output logic [1:0]               memDataWidth_Out,
  output logic                     memIsRead_Out,
  output logic                     memAccess_Out,
  input  logic                     memAccessOK_In,
  input  logic [31:0]              memData_In,
  input  logic [EXCEPTION_LEN-1:0] memException_In
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t                   r_state;
  logic [31:0]              r_fetch_pc;
  logic [31:0]              r_mem_addr;
  logic                     r_mem_access;
  logic [CNT_W-1:0]         r_count;
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [31:0]              r_fifo_instr [DEPTH];
  logic [31:0]              r_fifo_pc    [DEPTH];
  logic [EXCEPTION_LEN-1:0] r_fifo_exc   [DEPTH];
  logic                     r_valid;
  logic [31:0]              r_head_instr;
  logic [31:0]              r_head_pc;
  logic [EXCEPTION_LEN-1:0] r_head_exc;

  logic [31:0]              w_flush_pc;
  logic                     w_resp;
  logic                     w_fifo_pop;
  logic                     w_push;
  logic [CNT_W-1:0]         w_left;
  logic [CNT_W-1:0]         w_count_nxt;
  logic [PTR_W-1:0]         w_rptr_nxt;
  logic                     w_valid_nxt;
  logic [31:0]              w_instr_nxt;
  logic [31:0]              w_pc_nxt;
  logic [EXCEPTION_LEN-1:0] w_exc_nxt;
`ifdef PREFETCH_BYPASS_EN
  logic                     w_bypass;
`endif

  // Push/pop decode and next head entry (head is a registered FIFO read)
  always_comb begin
    w_flush_pc  = pcWrite_In & ~32'h3;
    w_resp      = (r_state == S_REQ) && memAccessOK_In && !pcFlush_In;
    w_fifo_pop  = pop_In && r_valid && !pcFlush_In;
`ifdef PREFETCH_BYPASS_EN
    w_bypass    = w_resp && !r_valid;
    w_push      = w_resp && !(w_bypass && pop_In);
`else
    w_push      = w_resp;
`endif
    w_left      = r_count - CNT_W'(w_fifo_pop);
    w_count_nxt = w_left + CNT_W'(w_push);
    w_rptr_nxt  = r_rptr + PTR_W'(w_fifo_pop);
    w_valid_nxt = 1'b0;
    w_instr_nxt = 32'h0;
    w_pc_nxt    = 32'h0;
    w_exc_nxt   = EXCEP_OK;
    if (!pcFlush_In) begin
      if (w_push && (w_left == '0)) begin
        w_valid_nxt = 1'b1;
        w_instr_nxt = memData_In;
        w_pc_nxt    = r_fetch_pc;
        w_exc_nxt   = memException_In;
      end else if (w_left != '0) begin
        w_valid_nxt = 1'b1;
        w_instr_nxt = r_fifo_instr[w_rptr_nxt];
        w_pc_nxt    = r_fifo_pc[w_rptr_nxt];
        w_exc_nxt   = r_fifo_exc[w_rptr_nxt];
      end
    end
  end

  // FIFO storage; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_fifo_instr[r_wptr] <= memData_In;
      r_fifo_pc[r_wptr]    <= r_fetch_pc;
      r_fifo_exc[r_wptr]   <= memException_In;
    end
  end

  // FIFO pointers, occupancy and registered head outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_valid      <= 1'b0;
      r_head_instr <= 32'h0;
      r_head_pc    <= 32'h0;
      r_head_exc   <= EXCEP_OK;
    end else begin
      if (pcFlush_In) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_count <= w_count_nxt;
        r_rptr  <= w_rptr_nxt;
        if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      end
      r_valid      <= w_valid_nxt;
      r_head_instr <= w_instr_nxt;
      r_head_pc    <= w_pc_nxt;
      r_head_exc   <= w_exc_nxt;
    end
  end

  // Fetch FSM: one outstanding request, fetch PC and registered request outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_fetch_pc   <= RESET_PC;
      r_mem_addr   <= RESET_PC;
      r_mem_access <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pcFlush_In) begin
            r_fetch_pc <= w_flush_pc;
          end else if ((r_count < CNT_W'(DEPTH)) && !execLockRead_In) begin
            r_state      <= S_REQ;
            r_mem_access <= 1'b1;
            r_mem_addr   <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (memAccessOK_In) begin
            r_mem_access <= 1'b0;
            if (pcFlush_In) begin
              // response in the flush cycle is dropped; request is complete
              r_state    <= S_IDLE;
              r_fetch_pc <= w_flush_pc;
            end else if (memException_In == EXCEP_OK) begin
              r_state    <= S_IDLE;
              r_fetch_pc <= r_fetch_pc + 32'd4;
            end else begin
              r_state <= S_HALT;
            end
          end else if (pcFlush_In) begin
            r_state    <= S_DISCARD;
            r_fetch_pc <= w_flush_pc;
          end
        end
        S_DISCARD: begin
          if (pcFlush_In) r_fetch_pc <= w_flush_pc;
          if (memAccessOK_In) begin
            r_state      <= S_IDLE;
            r_mem_access <= 1'b0;
          end
        end
        S_HALT: begin
          if (pcFlush_In) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= w_flush_pc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output drive
`ifdef PREFETCH_BYPASS_EN
  assign valid_Out     = r_valid | w_bypass;
  assign instr_Out     = w_bypass ? memData_In      : r_head_instr;
  assign pc_Out        = w_bypass ? r_fetch_pc      : r_head_pc;
  assign exception_Out = w_bypass ? memException_In : r_head_exc;
`else
  assign valid_Out     = r_valid;
  assign instr_Out     = r_head_instr;
  assign pc_Out        = r_head_pc;
  assign exception_Out = r_head_exc;
`endif
  assign memAddr_Out      = r_mem_addr;
  assign memAccess_Out    = r_mem_access;
  assign memData_Out      = 32'h0;
  assign memDataWidth_Out = 2'b10;
  assign memIsRead_Out    = 1'b1;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: randomized consumer, flush,
// lock and arbiter latency against a transaction-level prefetch model.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [3:0]  EXC_OK   = 4'h0;
  localparam logic [3:0]  EXC_CODE = 4'h5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  exc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcWrite_In;
  logic        pcFlush_In;
  logic        pop_In;
  logic        execLockRead_In;
  logic        valid_Out;
  logic [31:0] instr_Out;
  logic [31:0] pc_Out;
  logic [3:0]  exception_Out;
  logic [31:0] memAddr_Out;
  logic [31:0] memData_Out;
  logic [1:0]  memDataWidth_Out;
  logic        memIsRead_Out;
  logic        memAccess_Out;
  logic        memAccessOK_In;
  logic [31:0] memData_In;
  logic [3:0]  memException_In;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .EXCEPTION_LEN(4), .EXCEP_OK(EXC_OK)) dut (
    .clk(clk), .rst(rst), .pcWrite_In(pcWrite_In), .pcFlush_In(pcFlush_In), .pop_In(pop_In),
    .execLockRead_In(execLockRead_In), .valid_Out(valid_Out), .instr_Out(instr_Out), .pc_Out(pc_Out),
    .exception_Out(exception_Out), .memAddr_Out(memAddr_Out), .memData_Out(memData_Out),
    .memDataWidth_Out(memDataWidth_Out), .memIsRead_Out(memIsRead_Out), .memAccess_Out(memAccess_Out),
    .memAccessOK_In(memAccessOK_In), .memData_In(memData_In), .memException_In(memException_In));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // stimulus controls
  logic        rst_req     = 1'b0;
  logic        mon_en      = 1'b0;
  int unsigned pop_pct     = 0;
  int unsigned flush_pct   = 0;
  int unsigned lock_pct    = 0;
  logic        lock_force  = 1'b0;
  logic        force_flush = 1'b0;
  logic [31:0] flush_tgt   = 32'h0;
  int unsigned arb_min     = 0;
  int unsigned arb_max     = 0;
  int unsigned arb_wait    = 0;
  logic        exc_en      = 1'b0;
  logic [7:0]  exc_lo      = 8'h10;
  logic [31:0] req_log [$];

  // reference model state
  ent_t        sb [$];
  logic [31:0] m_pc;
  logic        m_halted, m_discard;
  logic        p_have, p_access, p_ok, p_flush, p_lock;
  int unsigned p_size;
  logic [31:0] p_addr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [3:0] excf(input logic [31:0] a);
    return (exc_en && (a[7:0] == exc_lo)) ? EXC_CODE : EXC_OK;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // One cycle: arbiter responds, then consumer/redirect/lock inputs, all at negedge
  task automatic step();
    logic [31:0] t;
    @(negedge clk);
    rst = rst_req;
    memAccessOK_In = 1'b0;
    if (!memAccess_Out) begin
      arb_wait = $urandom_range(arb_max, arb_min);
    end else if (arb_wait == 0) begin
      memAccessOK_In  = 1'b1;
      memData_In      = rom(memAddr_Out);
      memException_In = excf(memAddr_Out);
      req_log.push_back(memAddr_Out);
    end else begin
      arb_wait--;
    end
    pop_In = ($urandom_range(99, 0) < pop_pct);
    execLockRead_In = lock_force || ($urandom_range(99, 0) < lock_pct);
    pcFlush_In = force_flush || ($urandom_range(99, 0) < flush_pct);
    if (force_flush) begin
      pcWrite_In = flush_tgt;
    end else begin
      t = $urandom;
      pcWrite_In = (t[3:0] == 4'h0) ? (32'hFFFF_FFF0 | {28'h0, t[7:4]}) : {22'h0, t[9:0]};
    end
    force_flush = 1'b0;
    #2;
  endtask

  // Monitor: protocol timing, head visibility and scoreboard pops each cycle
  initial begin
    ent_t e;
    int unsigned size0;
    logic ok, fl, acc, exp_valid;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        sb.delete();
        m_pc = RESET_PC; m_halted = 1'b0; m_discard = 1'b0; p_have = 1'b0;
      end else begin
        size0 = sb.size();
        ok = memAccessOK_In; fl = pcFlush_In;
        acc = ok && !fl && !m_discard;
        exp_valid = (size0 != 0);
`ifdef PREFETCH_BYPASS_EN
        if (acc && size0 == 0) exp_valid = 1'b1;
`endif
        check("valid_Out", 32'(valid_Out), 32'(exp_valid));
        if (!valid_Out) check("empty_exception", 32'(exception_Out), 32'(EXC_OK));
        if (p_have) begin
          if (p_access && !p_ok) begin
            check("req_held", 32'(memAccess_Out), 32'd1);
            check("req_addr_stable", memAddr_Out, p_addr);
          end else if (p_access && p_ok) begin
            check("req_drop_after_ok", 32'(memAccess_Out), 32'd0);
          end else begin
            check("issue_rule", 32'(memAccess_Out),
                  32'(!p_flush && !p_lock && (p_size < DEPTH) && !m_halted));
          end
        end
        if (fl) begin
          if (memAccess_Out) m_discard = !ok;
          sb.delete();
          m_pc = pcWrite_In & ~32'h3;
          m_halted = 1'b0;
        end else if (ok) begin
          if (m_discard) begin
            m_discard = 1'b0;
          end else begin
            check("req_addr", memAddr_Out, m_pc);
            e.pc = m_pc; e.instr = rom(m_pc); e.exc = excf(m_pc);
            sb.push_back(e);
            if (e.exc == EXC_OK) m_pc = m_pc + 32'd4;
            else m_halted = 1'b1;
          end
        end
        if (!fl && valid_Out && pop_In) begin
          if (sb.size() == 0) begin
            check("pop_underflow", 32'(valid_Out), 32'd0);
          end else begin
            e = sb.pop_front();
            check("pop_pc", pc_Out, e.pc);
            check("pop_instr", instr_Out, e.instr);
            check("pop_exc", 32'(exception_Out), 32'(e.exc));
          end
        end
        p_access = memAccess_Out; p_ok = ok; p_flush = fl; p_lock = execLockRead_In;
        p_size = size0; p_addr = memAddr_Out; p_have = 1'b1;
      end
    end
  end

  task automatic do_reset();
    rst_req = 1'b0; mon_en = 1'b0;
    repeat (3) step();
    rst_req = 1'b1; mon_en = 1'b1;
  endtask

  initial begin
    int n;
    logic hit;
    rst = 1'b0; pcWrite_In = 32'h0; pcFlush_In = 1'b0; pop_In = 1'b0; execLockRead_In = 1'b0;
    memAccessOK_In = 1'b0; memData_In = 32'h0; memException_In = 4'h0;

    // reset values
    rst_req = 1'b0;
    repeat (3) step();
    check("rst_access", 32'(memAccess_Out), 32'd0);
    check("rst_valid", 32'(valid_Out), 32'd0);
    check("rst_instr", instr_Out, 32'h0);
    check("rst_pc", pc_Out, 32'h0);
    check("rst_exc", 32'(exception_Out), 32'(EXC_OK));
    check("rst_addr", memAddr_Out, RESET_PC);
    check("const_width", 32'(memDataWidth_Out), 32'd2);
    check("const_isread", 32'(memIsRead_Out), 32'd1);
    check("const_data", memData_Out, 32'h0);

    // fill with no consumer: 0,4,8,C then stop
    rst_req = 1'b1; mon_en = 1'b1;
    req_log.delete();
    repeat (20) step();
    check("fill_reqs", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < req_log.size(); i++) check("fill_addr", req_log[i], 32'(4 * i));
    check("fill_valid", 32'(valid_Out), 32'd1);
    check("fill_pc", pc_Out, 32'h0);
    check("fill_instr", instr_Out, rom(32'h0));
    check("fill_stopped", 32'(memAccess_Out), 32'd0);

    // redirect from IDLE to 0xFFFFFFFC wraps to 0
    req_log.delete();
    pop_pct = 100; force_flush = 1'b1; flush_tgt = 32'hFFFF_FFFE;
    repeat (8) step();
    check("wrap_nreq", 32'(req_log.size() >= 2), 32'd1);
    if (req_log.size() >= 2) begin
      check("wrap_addr0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", req_log[1], 32'h0);
    end

    // steady state: pop every cycle
    repeat (40) step();

    // flush while request to 0x8 outstanding
    pop_pct = 0; arb_min = 2; arb_max = 2;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = memAccess_Out && (memAddr_Out == 32'h8);
    end
    check("flush_found_req8", 32'(hit), 32'd1);
    force_flush = 1'b1; flush_tgt = 32'h103;
    step();
    step();
    check("flush_empty", 32'(valid_Out), 32'd0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (!(memAccess_Out && memAddr_Out != 32'h8)) step();
      else hit = 1'b1;
    end
    check("flush_new_req", 32'(hit), 32'd1);
    check("flush_new_addr", memAddr_Out, 32'h100);
    repeat (10) step();

    // exception at 0x10 halts fetch
    arb_min = 0; arb_max = 0; exc_en = 1'b1; exc_lo = 8'h10; pop_pct = 100;
    do_reset();
    req_log.delete();
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      step();
      hit = valid_Out && (pc_Out == 32'h10);
    end
    check("exc_seen", 32'(hit), 32'd1);
    check("exc_code", 32'(exception_Out), 32'(EXC_CODE));
    repeat (10) step();
    check("halt_noreq", 32'(memAccess_Out), 32'd0);
    check("halt_nreq", 32'(req_log.size()), 32'd5);
    check("halt_empty", 32'(valid_Out), 32'd0);

    // lock for 5 cycles while idle; flush to 0 in the first one
    lock_force = 1'b1; force_flush = 1'b1; flush_tgt = 32'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_noreq", 32'(memAccess_Out), 32'd0);
    end
    lock_force = 1'b0;
    step();
    check("lock_drop_noreq", 32'(memAccess_Out), 32'd0);
    step();
    check("lock_first_issue", 32'(memAccess_Out), 32'd1);
    check("lock_resume_addr", memAddr_Out, 32'h0);

    // randomized traffic
    exc_lo = 8'h2C; arb_max = 3; flush_pct = 3; lock_pct = 10;
    for (int blk = 0; blk < 15; blk++) begin
      pop_pct = $urandom_range(90, 30);
      repeat (200) step();
    end

    // fill to DEPTH under lock-free run, then lock and drain
    flush_pct = 0; lock_pct = 0; exc_en = 1'b0; pop_pct = 0;
    force_flush = 1'b1; flush_tgt = 32'h200;
    repeat (40) step();
    lock_force = 1'b1;
    repeat (2) step();
    pop_pct = 100; n = 0;
    repeat (10) begin
      step();
      if (valid_Out) n++;
    end
    check("drain_count", 32'(n), 32'(DEPTH));
    lock_force = 1'b0;

    // reset in the middle of a request
    arb_min = 3; arb_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      hit = memAccess_Out;
    end
    check("mid_req_found", 32'(hit), 32'd1);
    rst_req = 1'b0; mon_en = 1'b0;
    step();
    step();
    check("mid_rst_access", 32'(memAccess_Out), 32'd0);
    check("mid_rst_valid", 32'(valid_Out), 32'd0);
    check("mid_rst_addr", memAddr_Out, RESET_PC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
